// File: rtl/tlc_lamp_monitor_pkg.sv
// ---------------------------------------------------------------------------
// tlc_mon_pkg
// Shared types and helpers for the traffic-light lamp monitor.
//   head_state_t : decoded state of one signal head (one lamp, none, several)
//   fault_code_t : first-fault code reported by the monitor
//   decode_head  : maps the three lamp bits of one head to a head_state_t
// ---------------------------------------------------------------------------
package tlc_mon_pkg;

  typedef enum logic [2:0] {
    HS_DARK  = 3'd0,
    HS_RED   = 3'd1,
    HS_YLW   = 3'd2,
    HS_GRN   = 3'd3,
    HS_MULTI = 3'd4
  } head_state_t;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_ENCODE   = 3'd2,
    FC_SEQ      = 3'd3,
    FC_DWELL    = 3'd4
  } fault_code_t;

  // Exactly one lamp lit gives that colour; none lit is dark; anything else is multi.
  function automatic head_state_t decode_head(input logic g, input logic y, input logic r);
    head_state_t hs;
    case ({g, y, r})
      3'b100:  hs = HS_GRN;
      3'b010:  hs = HS_YLW;
      3'b001:  hs = HS_RED;
      3'b000:  hs = HS_DARK;
      default: hs = HS_MULTI;
    endcase
    return hs;
  endfunction

endpackage

// File: rtl/tlc_lamp_monitor_if.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor_if
// Bundle between the controller side (master) and the lamp monitor (slave).
//   GRN1/YLW1/RED1, GRN2/YLW2/RED2 : lamp drives of head 1 and head 2
//   clr_fault                     : synchronous clear of the sticky fault
//   fault, fault_code             : sticky fault flag and first-fault code
//   lamp_ok                       : current sample free of violations
//   cycle_cnt                     : number of head-1 entries into green
// ---------------------------------------------------------------------------
interface tlc_lamp_monitor_if #(
  parameter int CNT_W = 8
);
  logic             GRN1;
  logic             YLW1;
  logic             RED1;
  logic             GRN2;
  logic             YLW2;
  logic             RED2;
  logic             clr_fault;
  logic             fault;
  logic [2:0]       fault_code;
  logic             lamp_ok;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output GRN1, YLW1, RED1, GRN2, YLW2, RED2, clr_fault,
    input  fault, fault_code, lamp_ok, cycle_cnt
  );

  modport slave (
    input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, clr_fault,
    output fault, fault_code, lamp_ok, cycle_cnt
  );
endinterface

// File: rtl/tlc_lamp_monitor_head_tracker.sv
// ---------------------------------------------------------------------------
// tlc_head_tracker
// Per-head decode, previous-state register, dwell counter and the
// encoding / sequence / dwell checks. All check outputs are combinational
// from the current lamps versus the previous sample; the top registers them.
//   g, y, r      : lamp inputs of this head
//   hs           : decoded current state
//   enc_err      : head dark or several lamps lit
//   seq_err      : illegal colour change (dark/multi changes excluded)
//   dwell_err    : green or yellow left too early
//   entered_grn  : head changes into green on this sample
// ---------------------------------------------------------------------------
module tlc_head_tracker
  import tlc_mon_pkg::*;
#(
  parameter int MIN_GRN_CYC = 8,
  parameter int MIN_YLW_CYC = 2,
  parameter int CNT_W       = 8
) (
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  input  logic        g,
  input  logic        y,
  input  logic        r,
  output head_state_t hs,
  output logic        enc_err,
  output logic        seq_err,
  output logic        dwell_err,
  output logic        entered_grn
);

  localparam logic [CNT_W-1:0] MIN_GRN_W = CNT_W'(MIN_GRN_CYC);
  localparam logic [CNT_W-1:0] MIN_YLW_W = CNT_W'(MIN_YLW_CYC);
  localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

  head_state_t      prev_hs_r;
  logic [CNT_W-1:0] dwell_r;
  logic             changed_s;
  logic             legal_s;
  logic             clean_s;

  // Decode and the checks against the previous sample; dwell is compared before update.
  always_comb begin
    hs        = decode_head(g, y, r);
    changed_s = (hs != prev_hs_r);
    enc_err   = (hs == HS_DARK) || (hs == HS_MULTI);
    case (prev_hs_r)
      HS_GRN:  legal_s = (hs == HS_YLW);
      HS_YLW:  legal_s = (hs == HS_RED);
      HS_RED:  legal_s = (hs == HS_GRN);
      default: legal_s = 1'b0;
    endcase
    // Transitions into or out of dark/multi are reported as encoding faults only.
    clean_s = (prev_hs_r != HS_DARK) && (prev_hs_r != HS_MULTI) &&
              (hs != HS_DARK) && (hs != HS_MULTI);
    seq_err = changed_s && clean_s && !legal_s;
    if (changed_s && (prev_hs_r == HS_GRN)) begin
      dwell_err = (dwell_r < MIN_GRN_W);
    end else if (changed_s && (prev_hs_r == HS_YLW)) begin
      dwell_err = (dwell_r < MIN_YLW_W);
    end else begin
      dwell_err = 1'b0;
    end
    entered_grn = (hs == HS_GRN) && (prev_hs_r != HS_GRN);
  end

  // Previous state and saturating dwell counter, updated every cycle.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      prev_hs_r <= HS_RED;
      dwell_r   <= '0;
    end else begin
      prev_hs_r <= hs;
      if (changed_s) begin
        dwell_r <= ONE_W;
      end else if (dwell_r != DWELL_MAX) begin
        dwell_r <= dwell_r + ONE_W;
      end
    end
  end

endmodule

// File: rtl/tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor
// Safety monitor on the six lamp outputs of the traffic-light controller.
// Holds the cross-head conflict check, fault priority, sticky first-fault
// capture, post-reset blanking and the head-1 green-entry counter.
//   blif_clk_net   : clock, rising edge
//   blif_reset_net : asynchronous active-high reset
//   mon            : lamps and clr_fault in; fault, fault_code, lamp_ok,
//                    cycle_cnt out (all outputs registered)
// ---------------------------------------------------------------------------
module tlc_lamp_monitor
  import tlc_mon_pkg::*;
#(
  parameter int MIN_GRN_CYC = 8,
  parameter int MIN_YLW_CYC = 2,
  parameter int BLANK_CYC   = 4,
  parameter int CNT_W       = 8
) (
  input logic               blif_clk_net,
  input logic               blif_reset_net,
  tlc_lamp_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] BLANK_W = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] ONE_W   = CNT_W'(1);

  head_state_t      hs1_s, hs2_s;
  logic             enc1_s, seq1_s, dwl1_s, ent1_s;
  logic             enc2_s, seq2_s, dwl2_s, ent2_s;
  logic             conflict_s;
  logic             blank_s;
  fault_code_t      viol_s;

  logic             fault_r;
  fault_code_t      fault_code_r;
  logic             lamp_ok_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] blank_cnt_r;

  tlc_head_tracker #(
    .MIN_GRN_CYC (MIN_GRN_CYC),
    .MIN_YLW_CYC (MIN_YLW_CYC),
    .CNT_W       (CNT_W)
  ) u_head1 (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .g              (mon.GRN1),
    .y              (mon.YLW1),
    .r              (mon.RED1),
    .hs             (hs1_s),
    .enc_err        (enc1_s),
    .seq_err        (seq1_s),
    .dwell_err      (dwl1_s),
    .entered_grn    (ent1_s)
  );

  tlc_head_tracker #(
    .MIN_GRN_CYC (MIN_GRN_CYC),
    .MIN_YLW_CYC (MIN_YLW_CYC),
    .CNT_W       (CNT_W)
  ) u_head2 (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .g              (mon.GRN2),
    .y              (mon.YLW2),
    .r              (mon.RED2),
    .hs             (hs2_s),
    .enc_err        (enc2_s),
    .seq_err        (seq2_s),
    .dwell_err      (dwl2_s),
    .entered_grn    (ent2_s)
  );

  // Conflict detection, blanking window and priority encoding of this sample.
  always_comb begin
    conflict_s = ((hs1_s == HS_GRN) || (hs1_s == HS_YLW)) &&
                 ((hs2_s == HS_GRN) || (hs2_s == HS_YLW));
    blank_s    = (blank_cnt_r < BLANK_W);
    if (blank_s) begin
      viol_s = FC_NONE;
    end else if (conflict_s) begin
      viol_s = FC_CONFLICT;
    end else if (enc1_s || enc2_s) begin
      viol_s = FC_ENCODE;
    end else if (seq1_s || seq2_s) begin
      viol_s = FC_SEQ;
    end else if (dwl1_s || dwl2_s) begin
      viol_s = FC_DWELL;
    end else begin
      viol_s = FC_NONE;
    end
  end

  // Sticky first fault, lamp_ok, blanking counter and green-entry counter.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
      lamp_ok_r    <= 1'b1;
      cycle_cnt_r  <= '0;
      blank_cnt_r  <= '0;
    end else begin
      if (blank_s) begin
        blank_cnt_r <= blank_cnt_r + ONE_W;
      end
      lamp_ok_r <= (viol_s == FC_NONE);
      // A violation coinciding with clr_fault reloads the code rather than clearing.
      if (viol_s != FC_NONE) begin
        if (!fault_r || mon.clr_fault) begin
          fault_r      <= 1'b1;
          fault_code_r <= viol_s;
        end
      end else if (mon.clr_fault) begin
        fault_r      <= 1'b0;
        fault_code_r <= FC_NONE;
      end
      if (ent1_s && !blank_s) begin
        cycle_cnt_r <= cycle_cnt_r + ONE_W;
      end
    end
  end

  assign mon.fault      = fault_r;
  assign mon.fault_code = fault_code_r;
  assign mon.lamp_ok    = lamp_ok_r;
  assign mon.cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_lamp_monitor
// Directed self-checking bench for tlc_lamp_monitor with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same offset after the following edge.
// ---------------------------------------------------------------------------
module tb_tlc_lamp_monitor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  tlc_lamp_monitor_if #(.CNT_W(8)) bus ();

  tlc_lamp_monitor #(
    .MIN_GRN_CYC (8),
    .MIN_YLW_CYC (2),
    .BLANK_CYC   (4),
    .CNT_W       (8)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .mon            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic [2:0] h1, input logic [2:0] h2);
    {bus.GRN1, bus.YLW1, bus.RED1} = h1;
    {bus.GRN2, bus.YLW2, bus.RED2} = h2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic f, input logic [2:0] fc,
                         input logic ok, input logic [7:0] cc);
    chk({tag, ".fault"},      32'(bus.fault),      32'(f));
    chk({tag, ".fault_code"}, 32'(bus.fault_code), 32'(fc));
    chk({tag, ".lamp_ok"},    32'(bus.lamp_ok),    32'(ok));
    chk({tag, ".cycle_cnt"},  32'(bus.cycle_cnt),  32'(cc));
  endtask

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] D = 3'b000;
  localparam logic [2:0] GY = 3'b110;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.clr_fault = 1'b0;
    lamps(R, R);
    tick(2);
    chk_out("reset", 1'b0, 3'd0, 1'b1, 8'd0);

    // Blanking: an illegal RED->YLW on head 1 is ignored for the first 4 edges.
    rst = 1'b0;
    lamps(Y, R);
    tick(3);
    chk_out("blank_ylw", 1'b0, 3'd0, 1'b1, 8'd0);
    lamps(R, R);
    tick(1);
    chk_out("blank_red", 1'b0, 3'd0, 1'b1, 8'd0);

    // Two full legal signal cycles.
    for (int k = 0; k < 2; k++) begin
      lamps(G, R); tick(8);
      lamps(Y, R); tick(2);
      lamps(R, G); tick(8);
      lamps(R, Y); tick(2);
    end
    lamps(R, R); tick(1);
    chk_out("legal_run", 1'b0, 3'd0, 1'b1, 8'd2);

    // Conflict, then a dark head that must not overwrite the first code.
    lamps(G, G); tick(1);
    chk_out("conflict", 1'b1, 3'd1, 1'b0, 8'd3);
    lamps(G, D); tick(1);
    chk_out("dark_sticky", 1'b1, 3'd1, 1'b0, 8'd3);
    bus.clr_fault = 1'b1;
    lamps(G, R); tick(1);
    bus.clr_fault = 1'b0;
    chk_out("clear1", 1'b0, 3'd0, 1'b1, 8'd3);

    // Finish the green legally, then a short green of 5 cycles.
    tick(5);
    lamps(Y, R); tick(2);
    lamps(R, R); tick(1);
    lamps(G, R); tick(5);
    chk_out("short_grn_pre", 1'b0, 3'd0, 1'b1, 8'd4);
    lamps(Y, R); tick(1);
    chk_out("dwell", 1'b1, 3'd4, 1'b0, 8'd4);
    bus.clr_fault = 1'b1;
    tick(1);
    bus.clr_fault = 1'b0;
    chk_out("clear2", 1'b0, 3'd0, 1'b1, 8'd4);

    // GRN->RED after 10 green cycles is a sequence fault.
    lamps(R, R); tick(1);
    lamps(G, R); tick(10);
    chk_out("long_grn", 1'b0, 3'd0, 1'b1, 8'd5);
    lamps(R, R); tick(1);
    chk_out("seq", 1'b1, 3'd3, 1'b0, 8'd5);
    bus.clr_fault = 1'b1;
    tick(1);
    bus.clr_fault = 1'b0;
    chk_out("clear3", 1'b0, 3'd0, 1'b1, 8'd5);

    // Two lamps on one head, then back to red: code sticks, lamp_ok recovers.
    lamps(GY, R); tick(1);
    chk_out("multi", 1'b1, 3'd2, 1'b0, 8'd5);
    lamps(R, R); tick(1);
    chk_out("multi_after", 1'b1, 3'd2, 1'b1, 8'd5);

    // clr_fault together with conflict (and a head-2 sequence fault): conflict wins.
    bus.clr_fault = 1'b1;
    lamps(G, Y); tick(1);
    bus.clr_fault = 1'b0;
    chk_out("clr_conflict", 1'b1, 3'd1, 1'b0, 8'd6);

    // Asynchronous reset mid-phase, then blanking restarts for 4 edges.
    lamps(G, R); tick(2);
    rst = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 3'd0, 1'b1, 8'd0);
    tick(1);
    rst = 1'b0;
    lamps(G, G);
    tick(4);
    chk_out("reblank", 1'b0, 3'd0, 1'b1, 8'd0);
    tick(1);
    chk_out("post_blank", 1'b1, 3'd1, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
